note_recorder: RTL

Captures a melody played on the 8 note keys into an internal note buffer, then plays it back as a timed stream of 5-bit note codes. The note encoding and beat rate match the song/LED/buzzer path, so the playback output can feed the note-to-LED and note-to-buzzer blocks directly. Sits beside the tip-music game and acts as the source that writes songs instead of reading them.

---
 rtl/note_pkg.sv | 35 +++
 rtl/beat_tick_gen.sv | 24 ++
 rtl/note_recorder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/note_pkg.sv
// Note codes, recorder states and the key/LED encoding helpers shared by the
// note recorder and the song/LED/buzzer path.
package note_pkg;

  localparam logic [4:0] NOTE_REST = 5'b00000;
  localparam logic [4:0] NOTE_DO   = 5'b01000;
  localparam logic [4:0] NOTE_RE   = 5'b01001;
  localparam logic [4:0] NOTE_MI   = 5'b01010;
  localparam logic [4:0] NOTE_FA   = 5'b01011;
  localparam logic [4:0] NOTE_SO   = 5'b01100;
  localparam logic [4:0] NOTE_LA   = 5'b01101;
  localparam logic [4:0] NOTE_SI   = 5'b01110;
  localparam logic [4:0] NOTE_HDO  = 5'b10000;

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  // Scanning from the top down leaves the lowest pressed key as the winner.
  function automatic logic [4:0] key_to_note(input logic [7:0] key);
    logic [4:0] code;
    code = NOTE_REST;
    for (int i = 7; i >= 0; i--) begin
      if (key[i]) code = (i == 7) ? NOTE_HDO : NOTE_DO + 5'(i);
    end
    return code;
  endfunction

  function automatic logic [7:0] note_to_onehot(input logic [4:0] code);
    logic [7:0] oh;
    oh = '0;
    if (code == NOTE_HDO) oh = 8'h80;
    else if (code[4:3] == 2'b01 && code[2:0] != 3'b111) oh[code[2:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/beat_tick_gen.sv
// Beat divider: one-cycle tick every TICK_DIV clocks, restartable so the first
// tick lands exactly TICK_DIV clocks after a clear.
module beat_tick_gen #(
  parameter int TICK_DIV = 4686914
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/note_recorder.sv
// Records key presses as {code, duration} entries and replays them as a
// beat-timed note stream compatible with the LED/buzzer path.
module note_recorder
  import note_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 4686914,
  parameter int DUR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        key,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  output logic [4:0]        note,
  output logic              note_valid,
  output logic [7:0]        LED,
  output logic [ADDR_W:0]   rec_count,
  output logic              busy,
  output logic              full,
  output logic              done
);

  localparam int ENT_W = 5 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ENT_W-1:0] mem [DEPTH];

  state_t           state;
  logic             tick, tick_clr, commit, open_ok;
  logic [4:0]       key_code, cur_code, first_code, next_code;
  logic [DUR_W-1:0] dur, tcnt, play_dur;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]  idx_next;

  beat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign key_code   = key_to_note(key);
  assign tick_clr   = (state == IDLE) && (rec_start || (play_start && rec_count != '0));
  assign idx_next   = {1'b0, idx} + (ADDR_W + 1)'(1);
  assign first_code = mem[0][ENT_W-1 -: 5];
  assign next_code  = mem[idx_next[ADDR_W-1:0]][ENT_W-1 -: 5];
  assign play_dur   = mem[idx][DUR_W-1:0];

  // A held note closes on release, on a change of code, or on stop; a new one
  // may open only if the buffer still has room after that commit.
  assign commit  = (state == REC) && (cur_code != NOTE_REST) && (stop || key_code != cur_code);
  assign open_ok = !stop && key_code != NOTE_REST && key_code != cur_code &&
                   (rec_count + (ADDR_W + 1)'(commit)) < DEPTH_C;

  always_ff @(posedge clk) begin
    if (!rst && commit)
      mem[rec_count[ADDR_W-1:0]] <= {cur_code, (dur == '0) ? DUR_W'(1) : dur};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note       <= NOTE_REST;
      note_valid <= 1'b0;
      LED        <= '0;
      rec_count  <= '0;
      busy       <= 1'b0;
      full       <= 1'b0;
      done       <= 1'b0;
      cur_code   <= NOTE_REST;
      dur        <= '0;
      idx        <= '0;
      tcnt       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rec_start) begin
            state     <= REC;
            busy      <= 1'b1;
            rec_count <= '0;
            full      <= 1'b0;
            cur_code  <= NOTE_REST;
            dur       <= '0;
          end else if (play_start) begin
            if (rec_count == '0) begin
              done <= 1'b1;
            end else begin
              state      <= PLAY;
              busy       <= 1'b1;
              idx        <= '0;
              tcnt       <= '0;
              note       <= first_code;
              note_valid <= 1'b1;
              LED        <= note_to_onehot(first_code);
            end
          end
        end
        REC: begin
          LED <= note_to_onehot(key_code);
          if (commit) begin
            rec_count <= rec_count + (ADDR_W + 1)'(1);
            full      <= (rec_count + (ADDR_W + 1)'(1)) == DEPTH_C;
          end
          if (stop) begin
            state    <= IDLE;
            busy     <= 1'b0;
            LED      <= '0;
            cur_code <= NOTE_REST;
          end else if (key_code != cur_code) begin
            cur_code <= open_ok ? key_code : NOTE_REST;
            dur      <= '0;
          end else if (cur_code != NOTE_REST && tick && dur != DUR_MAX) begin
            dur <= dur + DUR_W'(1);
          end
        end
        PLAY: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            note       <= NOTE_REST;
            note_valid <= 1'b0;
            LED        <= '0;
          end else if (tick) begin
            if (({1'b0, tcnt} + (DUR_W + 1)'(1)) >= {1'b0, play_dur}) begin
              tcnt <= '0;
              if (idx_next == rec_count) begin
                state      <= IDLE;
                busy       <= 1'b0;
                note       <= NOTE_REST;
                note_valid <= 1'b0;
                LED        <= '0;
                done       <= 1'b1;
              end else begin
                idx  <= idx_next[ADDR_W-1:0];
                note <= next_code;
                LED  <= note_to_onehot(next_code);
              end
            end else begin
              tcnt <= tcnt + DUR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
